// File: rtl/mac_pkg.sv
// mac_pkg: shared sizes, FSM encoding and config clamp for the MAC output writer.
package mac_pkg;
    localparam int COLS          = 8;
    localparam int PSUM_W        = 16;
    localparam int FIFO_D        = 8;
    localparam int ADDR_O_W      = 4;
    localparam int WORDS_PER_ROW = 2;
    localparam int ROW_W         = COLS * PSUM_W;
    localparam int WORD_W        = ROW_W / WORDS_PER_ROW;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, FIN} state_t;

    function automatic logic [3:0] clamp_cfg(input logic [3:0] v);
        return (v == 4'd0 || v > 4'd8) ? 4'd8 : v;
    endfunction
endpackage

// File: rtl/mac_row_fifo.sv
// mac_row_fifo: synchronous first-word-fall-through row FIFO with same-cycle push and pop.
module mac_row_fifo
    import mac_pkg::*;
#(
    parameter int W = ROW_W,
    parameter int D = FIFO_D
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);
    localparam int AW = $clog2(D);

    logic [W-1:0] mem [D];
    logic [AW-1:0] wp, rp;
    logic [AW:0] cnt;
    logic do_push, do_pop;

    assign full    = cnt == (AW+1)'(D);
    assign empty   = cnt == '0;
    assign dout    = mem[rp];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge CLK) begin
        if (RST) begin
            wp  <= '0;
            rp  <= '0;
            cnt <= '0;
        end else begin
            if (do_push) begin
                mem[wp] <= din;
                wp      <= wp + 1'b1;
            end
            if (do_pop) rp <= rp + 1'b1;
            cnt <= cnt + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
        end
    end
endmodule

// File: rtl/mac_out_writer.sv
// mac_out_writer: deskews systolic-array column sums into rows, buffers them and writes 64-bit words to OUT_MEM.
module mac_out_writer
    import mac_pkg::*;
(
    input  logic                     CLK,
    input  logic                     RST,
    input  logic                     START,
    input  logic [3:0]               CFG_M,
    input  logic [3:0]               CFG_T,
    input  logic [COLS-1:0]          PSUM_VLD,
    input  logic [COLS*PSUM_W-1:0]   PSUM,
    output logic                     EN_O,
    output logic                     RW_O,
    output logic [ADDR_O_W-1:0]      ADDR_O,
    output logic [WORD_W-1:0]        WDATA_O,
    output logic                     DONE,
    output logic                     ERR
);
    state_t state_q, state_d;
    logic [3:0] m_q, t_q, rows_in, rows_out;
    logic half;
    logic [COLS-1:0] al_v, t_mask;
    logic [PSUM_W-1:0] al_d [COLS];
    logic [ROW_W-1:0] row_d, head;
    logic row_vld, mismatch, push, pop, full, empty, start_ok, err_set;
    logic [ADDR_O_W-1:0] addr_q;
    logic [WORD_W-1:0] data_q;

    // Column c is held back COLS-1-c cycles so every column of a row lines up with column COLS-1.
    for (genvar c = 0; c < COLS; c++) begin : g_col
        localparam int D = COLS - 1 - c;
        if (D == 0) begin : g_pass
            assign al_v[c] = PSUM_VLD[c];
            assign al_d[c] = PSUM[c*PSUM_W +: PSUM_W];
        end else begin : g_dly
            logic [D-1:0] v;
            logic [PSUM_W-1:0] d [D];
            always_ff @(posedge CLK) begin
                if (RST) begin
                    v <= '0;
                    for (int i = 0; i < D; i++) d[i] <= '0;
                end else begin
                    v[0] <= PSUM_VLD[c];
                    d[0] <= PSUM[c*PSUM_W +: PSUM_W];
                    for (int i = 1; i < D; i++) begin
                        v[i] <= v[i-1];
                        d[i] <= d[i-1];
                    end
                end
            end
            assign al_v[c] = v[D-1];
            assign al_d[c] = d[D-1];
        end
    end

    always_comb begin
        row_d  = '0;
        t_mask = '0;
        for (int i = 0; i < COLS; i++) begin
            t_mask[i]                = 4'(i) < t_q;
            row_d[i*PSUM_W +: PSUM_W] = t_mask[i] ? al_d[i] : '0;
        end
    end

    assign row_vld  = al_v[0];
    assign mismatch = |(~al_v & t_mask);
    assign start_ok = START && state_q == IDLE;
    assign push     = row_vld && state_q == RUN && !full;
    assign err_set  = row_vld && (mismatch || state_q != RUN || full);

    mac_row_fifo u_fifo (
        .CLK   (CLK),
        .RST   (RST),
        .push  (push),
        .pop   (pop),
        .din   (row_d),
        .dout  (head),
        .full  (full),
        .empty (empty)
    );

    // Head row is written as two words; it leaves the FIFO on the second one.
    assign EN_O    = (state_q == RUN || state_q == DRAIN) && !empty;
    assign RW_O    = EN_O;
    assign pop     = EN_O && half;
    assign ADDR_O  = EN_O ? {rows_out[2:0], half} : addr_q;
    assign WDATA_O = EN_O ? (half ? head[ROW_W-1 -: WORD_W] : head[WORD_W-1:0]) : data_q;
    assign DONE    = state_q == FIN;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = START ? RUN : IDLE;
            RUN:     state_d = (push && rows_in == m_q - 4'd1) ? DRAIN : RUN;
            DRAIN:   state_d = (pop && rows_out == m_q - 4'd1) ? FIN : DRAIN;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= IDLE;
            m_q      <= '0;
            t_q      <= '0;
            rows_in  <= '0;
            rows_out <= '0;
            half     <= 1'b0;
            ERR      <= 1'b0;
            addr_q   <= '0;
            data_q   <= '0;
        end else begin
            state_q <= state_d;
            if (start_ok) begin
                m_q      <= clamp_cfg(CFG_M);
                t_q      <= clamp_cfg(CFG_T);
                rows_in  <= '0;
                rows_out <= '0;
                half     <= 1'b0;
                ERR      <= 1'b0;
            end else begin
                if (push) rows_in <= rows_in + 4'd1;
                if (pop) rows_out <= rows_out + 4'd1;
                if (EN_O) half <= ~half;
                if (err_set) ERR <= 1'b1;
            end
            if (EN_O) begin
                addr_q <= ADDR_O;
                data_q <= WDATA_O;
            end
        end
    end
endmodule
